// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC, issues in-order imem reads, tracks in-flight PCs, and
// buffers returned words in a DEPTH-entry queue for decode. A branch redirect
// (flushBack_i level) is acknowledged with a one-cycle flushAck_o pulse; queued
// and in-flight instructions are discarded, and late responses are drained.
// Ports:
//   clock_i, reset_i (async, active high)
//   enable_i                  - allow new requests
//   flushBack_i, branchPc_i   - redirect level + target
//   flushAck_o                - one-cycle redirect accepted pulse
//   imemReq_o/Addr_o/Gnt_i    - request channel (req & gnt = handshake)
//   imemRvalid_i/Rdata_i      - in-order response channel
//   instrValid_o/instr_o/instrPc_o, isStalled_i - decode-side queue head
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               flushBack_i,
  input  logic [ADDR_W-1:0]  branchPc_i,
  output logic               flushAck_o,
  output logic               imemReq_o,
  output logic [ADDR_W-1:0]  imemAddr_o,
  input  logic               imemGnt_i,
  input  logic               imemRvalid_i,
  input  logic [INSTR_W-1:0] imemRdata_i,
  output logic               instrValid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instrPc_o,
  input  logic               isStalled_i
);
  localparam int QW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {RUN, DRAIN} state_t;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } q_entry_t;

  state_t              state_q, state_d;
  logic [1:0]          out_q, out_d;     // outstanding requests (MAX_OUT <= 3)
  logic [1:0]          drop_q, drop_d;   // responses still to discard
  logic                ack_q;
  logic [ADDR_W-1:0]   fetch_pc_q;

  q_entry_t            q_mem [DEPTH];
  logic [QW-1:0]       q_head, q_tail;
  logic [CW-1:0]       q_cnt;

  logic [ADDR_W-1:0]   pf_mem [MAX_OUT]; // PCs of requests awaiting response
  logic [FW-1:0]       pf_rd, pf_wr;

  logic flush_acc, resp, room, req, gnt, push, pop;

  function automatic logic [FW-1:0] pf_inc(input logic [FW-1:0] p);
    return (int'(p) == MAX_OUT - 1) ? '0 : p + 1'b1;
  endfunction

  // The branch unit's level is still high during the ack cycle; ignore it then.
  assign flush_acc = flushBack_i & ~ack_q;
  // A response with nothing outstanding (e.g. after reset) is stale: drop it.
  assign resp      = imemRvalid_i & (out_q != 2'd0);
  // Issue only when a queue slot is reserved for every outstanding response.
  assign room      = (int'(q_cnt) + int'(out_q)) < DEPTH;
  assign req       = (state_q == RUN) & enable_i & ~flush_acc & room &
                     (int'(out_q) < MAX_OUT);
  assign gnt       = req & imemGnt_i;
  assign push      = resp & (state_q == RUN) & ~flush_acc;
  assign pop       = (q_cnt != '0) & ~isStalled_i & ~flush_acc;

  // Next-state / outstanding bookkeeping.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    out_d   = out_q;
    if (gnt && !resp)      out_d = out_q + 2'd1;
    else if (!gnt && resp) out_d = out_q - 2'd1;
    if (flush_acc) begin
      // No grant can happen here, so out_d already excludes a same-cycle response.
      drop_d  = out_d;
      state_d = (out_d != 2'd0) ? DRAIN : RUN;
    end else if (state_q == DRAIN && resp) begin
      drop_d = drop_q - 2'd1;
      if (drop_q == 2'd1) state_d = RUN;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      drop_q  <= '0;
      out_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      out_q   <= out_d;
      ack_q   <= flush_acc;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q <= '0;
      q_head     <= '0;
      q_tail     <= '0;
      q_cnt      <= '0;
      pf_rd      <= '0;
      pf_wr      <= '0;
      for (int i = 0; i < DEPTH; i++)   q_mem[i]  <= '0;
      for (int i = 0; i < MAX_OUT; i++) pf_mem[i] <= '0;
    end else if (flush_acc) begin
      fetch_pc_q <= branchPc_i;
      q_head     <= '0;
      q_tail     <= '0;
      q_cnt      <= '0;
      pf_rd      <= '0;
      pf_wr      <= '0;
    end else begin
      if (gnt) begin
        fetch_pc_q    <= fetch_pc_q + 1'b1;
        pf_mem[pf_wr] <= fetch_pc_q;
        pf_wr         <= pf_inc(pf_wr);
      end
      if (push) begin
        q_mem[q_tail] <= '{instr: imemRdata_i, pc: pf_mem[pf_rd]};
        q_tail        <= q_tail + 1'b1;
        pf_rd         <= pf_inc(pf_rd);
      end
      if (pop) q_head <= q_head + 1'b1;
      if (push && !pop)      q_cnt <= q_cnt + 1'b1;
      else if (!push && pop) q_cnt <= q_cnt - 1'b1;
    end
  end

  // Request is gated by reset so every output reads 0 while reset is held.
  assign imemReq_o    = req & ~reset_i;
  assign imemAddr_o   = fetch_pc_q;
  assign flushAck_o   = ack_q;
  assign instrValid_o = (q_cnt != '0);
  assign instr_o      = q_mem[q_head].instr;
  assign instrPc_o    = q_mem[q_head].pc;
endmodule
